// File: rtl/kbd_evq.sv
`default_nettype none
// ============================================================================
// Module   : kbd_evq
// Purpose  : PS/2 keyboard event queue. Decodes E0/F0 prefixed scancode
//            bytes into key events, tracks modifier state, queues events in
//            a DEPTH-entry FIFO and exposes DATA/STATUS/CTRL registers plus
//            a level interrupt on the peripheral bus.
// Options  : define KBD_TYPEMATIC_FILTER_EN to suppress auto-repeat makes
//            of the most recently pressed key.
// Revision : 1.0 - initial release
// ============================================================================
module kbd_evq #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        rw,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        ready,
    input  logic [7:0]  scancode,
    output logic        irq
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_EXT     = 2'd1;
    localparam logic [1:0] c_ST_BRK     = 2'd2;
    localparam logic [1:0] c_ST_EXT_BRK = 2'd3;

    localparam logic [1:0] c_REG_DATA   = 2'd0;
    localparam logic [1:0] c_REG_STATUS = 2'd1;
    localparam logic [1:0] c_REG_CTRL   = 2'd2;

    localparam logic [7:0] c_PFX_EXT    = 8'hE0;
    localparam logic [7:0] c_PFX_BRK    = 8'hF0;
    localparam logic [7:0] c_KEY_LSHIFT = 8'h12;
    localparam logic [7:0] c_KEY_RSHIFT = 8'h59;
    localparam logic [7:0] c_KEY_CTRL   = 8'h14;
    localparam logic [7:0] c_KEY_ALT    = 8'h11;
    localparam logic [7:0] c_KEY_CAPS   = 8'h58;

    localparam logic [PTR_W:0]   c_FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   c_CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] c_PTR_ONE  = PTR_W'(1);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             w_emit;
    logic             w_emit_ext;
    logic             w_emit_rel;
    logic             w_is_pfx;
    logic             w_repeat;
    logic             w_accept;

    logic             r_lshift, r_rshift, r_lctrl, r_rctrl, r_lalt, r_ralt, r_caps;
    logic             w_lshift_nxt, w_rshift_nxt, w_lctrl_nxt, w_rctrl_nxt;
    logic             w_lalt_nxt, w_ralt_nxt, w_caps_nxt;
    logic             w_shift_nxt, w_ctrl_nxt, w_alt_nxt;
    logic [13:0]      w_evt;

    logic             r_push;
    logic [13:0]      r_push_word;

    logic [13:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_ovf;
    logic             r_release_en;
    logic             r_irq_en;

    logic [1:0]       w_sel;
    logic             w_rd;
    logic             w_wr_ctrl;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_flush;
    logic             w_clr_ovf;
    logic             w_push_ok;
    logic             w_ovf_set;
    logic [31:0]      w_status;
    logic             w_unused;

    assign w_is_pfx = (scancode == c_PFX_EXT) || (scancode == c_PFX_BRK);

    // ------------------------------------------------------------------
    // Prefix decoder FSM
    // ------------------------------------------------------------------
    // State register: advances only when a byte arrives
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else if (ready) begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic from the current prefix context and incoming byte
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (scancode == c_PFX_EXT)      w_state_nxt = c_ST_EXT;
                else if (scancode == c_PFX_BRK) w_state_nxt = c_ST_BRK;
                else                            w_state_nxt = c_ST_IDLE;
            end
            c_ST_EXT: begin
                if (scancode == c_PFX_BRK)      w_state_nxt = c_ST_EXT_BRK;
                else if (scancode == c_PFX_EXT) w_state_nxt = c_ST_EXT;
                else                            w_state_nxt = c_ST_IDLE;
            end
            c_ST_BRK: begin
                // F0 E0 is an out-of-order prefix pair that keyboards emit
                if (scancode == c_PFX_EXT)      w_state_nxt = c_ST_EXT_BRK;
                else                            w_state_nxt = c_ST_IDLE;
            end
            c_ST_EXT_BRK: begin
                if (w_is_pfx)                   w_state_nxt = c_ST_EXT_BRK;
                else                            w_state_nxt = c_ST_IDLE;
            end
            default:                            w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Output logic: which byte completes an event and with which flags
    always_comb begin
        w_emit     = 1'b0;
        w_emit_ext = 1'b0;
        w_emit_rel = 1'b0;
        if (ready) begin
            case (r_state)
                c_ST_IDLE: begin
                    w_emit = !w_is_pfx;
                end
                c_ST_EXT: begin
                    w_emit     = !w_is_pfx;
                    w_emit_ext = 1'b1;
                end
                c_ST_BRK: begin
                    w_emit     = (scancode != c_PFX_EXT);
                    w_emit_rel = 1'b1;
                end
                c_ST_EXT_BRK: begin
                    w_emit     = !w_is_pfx;
                    w_emit_ext = 1'b1;
                    w_emit_rel = 1'b1;
                end
                default: begin
                    w_emit = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Auto-repeat filter
    // ------------------------------------------------------------------
`ifdef KBD_TYPEMATIC_FILTER_EN
    logic [8:0] r_held;
    logic       r_held_vld;
    logic       w_held_hit;

    assign w_held_hit = r_held_vld && (r_held == {w_emit_ext, scancode});
    assign w_repeat   = w_emit && !w_emit_rel && w_held_hit;

    // Held key follows the latest make; its own break releases it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_held     <= 9'd0;
            r_held_vld <= 1'b0;
        end else if (w_emit && !w_repeat) begin
            if (!w_emit_rel) begin
                r_held     <= {w_emit_ext, scancode};
                r_held_vld <= 1'b1;
            end else if (w_held_hit) begin
                r_held_vld <= 1'b0;
            end
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    assign w_accept = w_emit && !w_repeat;

    // ------------------------------------------------------------------
    // Modifier tracking
    // ------------------------------------------------------------------
    // Post-event modifier state; the event word carries these values
    always_comb begin
        w_lshift_nxt = r_lshift;
        w_rshift_nxt = r_rshift;
        w_lctrl_nxt  = r_lctrl;
        w_rctrl_nxt  = r_rctrl;
        w_lalt_nxt   = r_lalt;
        w_ralt_nxt   = r_ralt;
        w_caps_nxt   = r_caps;
        if (w_accept) begin
            if (!w_emit_ext && scancode == c_KEY_LSHIFT) w_lshift_nxt = !w_emit_rel;
            if (!w_emit_ext && scancode == c_KEY_RSHIFT) w_rshift_nxt = !w_emit_rel;
            if (!w_emit_ext && scancode == c_KEY_CTRL)   w_lctrl_nxt  = !w_emit_rel;
            if ( w_emit_ext && scancode == c_KEY_CTRL)   w_rctrl_nxt  = !w_emit_rel;
            if (!w_emit_ext && scancode == c_KEY_ALT)    w_lalt_nxt   = !w_emit_rel;
            if ( w_emit_ext && scancode == c_KEY_ALT)    w_ralt_nxt   = !w_emit_rel;
            if (!w_emit_ext && !w_emit_rel && scancode == c_KEY_CAPS) w_caps_nxt = !r_caps;
        end
    end

    assign w_shift_nxt = w_lshift_nxt | w_rshift_nxt;
    assign w_ctrl_nxt  = w_lctrl_nxt  | w_rctrl_nxt;
    assign w_alt_nxt   = w_lalt_nxt   | w_ralt_nxt;
    assign w_evt       = {w_caps_nxt, w_alt_nxt, w_ctrl_nxt, w_shift_nxt,
                          w_emit_rel, w_emit_ext, scancode};

    // Modifier registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lshift <= 1'b0;
            r_rshift <= 1'b0;
            r_lctrl  <= 1'b0;
            r_rctrl  <= 1'b0;
            r_lalt   <= 1'b0;
            r_ralt   <= 1'b0;
            r_caps   <= 1'b0;
        end else begin
            r_lshift <= w_lshift_nxt;
            r_rshift <= w_rshift_nxt;
            r_lctrl  <= w_lctrl_nxt;
            r_rctrl  <= w_rctrl_nxt;
            r_lalt   <= w_lalt_nxt;
            r_ralt   <= w_ralt_nxt;
            r_caps   <= w_caps_nxt;
        end
    end

    // Push staging: events enter the FIFO one cycle after their byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_push      <= 1'b0;
            r_push_word <= 14'd0;
        end else begin
            r_push      <= w_accept && (!w_emit_rel || r_release_en);
            r_push_word <= w_evt;
        end
    end

    // ------------------------------------------------------------------
    // Bus decode and FIFO control
    // ------------------------------------------------------------------
    assign w_sel     = addr[3:2];
    assign w_rd      = ena && !rw;
    assign w_wr_ctrl = ena && rw && (w_sel == c_REG_CTRL);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_FULL_CNT);
    assign w_pop     = w_rd && (w_sel == c_REG_DATA) && !w_empty;
    assign w_flush   = w_wr_ctrl && wdata[0];
    assign w_clr_ovf = w_wr_ctrl && wdata[1];
    // A same-cycle pop frees the slot that a push into a full FIFO needs
    assign w_push_ok = r_push && !w_flush && (!w_full || w_pop);
    assign w_ovf_set = r_push && !w_flush && w_full && !w_pop;

    // FIFO storage (no reset needed; only occupied slots are ever read)
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= r_push_word;
        end
    end

    // Pointers and occupancy count; flush wins over any pending push
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow and CTRL enables; a new overflow beats a same-cycle clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf        <= 1'b0;
            r_release_en <= 1'b0;
            r_irq_en     <= 1'b0;
        end else begin
            if (w_clr_ovf) r_ovf <= 1'b0;
            if (w_ovf_set) r_ovf <= 1'b1;
            if (w_wr_ctrl) begin
                r_release_en <= wdata[2];
                r_irq_en     <= wdata[3];
            end
        end
    end

    // ------------------------------------------------------------------
    // Register read-back and interrupt
    // ------------------------------------------------------------------
    // STATUS word assembly
    always_comb begin
        w_status          = 32'd0;
        w_status[PTR_W:0] = r_count;
        w_status[16]      = w_empty;
        w_status[17]      = w_full;
        w_status[18]      = r_ovf;
        w_status[19]      = r_lshift | r_rshift;
        w_status[20]      = r_lctrl  | r_rctrl;
        w_status[21]      = r_lalt   | r_ralt;
        w_status[22]      = r_caps;
    end

    // Read data is registered and returns to zero when no read occurred
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= 32'd0;
        end else if (w_rd) begin
            case (w_sel)
                c_REG_DATA:   rdata <= w_empty ? 32'd0 : {18'd0, r_mem[r_rd_ptr]};
                c_REG_STATUS: rdata <= w_status;
                c_REG_CTRL:   rdata <= {28'd0, r_irq_en, r_release_en, 2'b00};
                default:      rdata <= 32'd0;
            endcase
        end else begin
            rdata <= 32'd0;
        end
    end

    // Level interrupt while events are pending and enabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq <= 1'b0;
        end else begin
            irq <= r_irq_en && !w_empty;
        end
    end

    assign w_unused = ^{addr[31:4], addr[1:0], wdata[31:4]};

endmodule
`default_nettype wire

// File: tb/tb_kbd_evq.sv
`default_nettype none
// ============================================================================
// Module   : tb_kbd_evq
// Purpose  : Self-checking bench for kbd_evq: directed scenarios plus
//            randomized bytes and bus traffic against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kbd_evq;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b0;
    logic        rw = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        ready = 1'b0;
    logic [7:0]  scancode = 8'd0;
    logic        irq;

    kbd_evq #(.DEPTH(DEPTH)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .rw       (rw),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .scancode (scancode),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Single comparison point
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_q[$];
    bit          m_ovf, m_rel_en, m_irq_en;
    bit          m_ls, m_rs, m_lc, m_rc, m_la, m_ra, m_caps;
    bit          m_ext, m_brk;
    bit          m_pend;
    logic [31:0] m_pend_word;
    logic [8:0]  m_held;
    bit          m_held_vld;
    logic [31:0] last_rd;

    task automatic model_reset();
        m_q.delete();
        m_ovf = 0; m_rel_en = 0; m_irq_en = 0;
        m_ls = 0; m_rs = 0; m_lc = 0; m_rc = 0; m_la = 0; m_ra = 0; m_caps = 0;
        m_ext = 0; m_brk = 0; m_pend = 0; m_pend_word = 0;
        m_held = 0; m_held_vld = 0;
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'(m_q.size());
        s[16] = (m_q.size() == 0);
        s[17] = (m_q.size() == DEPTH);
        s[18] = m_ovf;
        s[19] = m_ls | m_rs;
        s[20] = m_lc | m_rc;
        s[21] = m_la | m_ra;
        s[22] = m_caps;
        return s;
    endfunction

    // A completed key event: filter, modifier update, push decision
    task automatic model_event(input bit ext, input bit rel, input logic [7:0] b,
                               output bit np, output logic [31:0] nw);
        np = 0;
        nw = 0;
`ifdef KBD_TYPEMATIC_FILTER_EN
        if (!rel && m_held_vld && m_held == {ext, b}) return;
        if (!rel) begin
            m_held = {ext, b};
            m_held_vld = 1;
        end else if (m_held_vld && m_held == {ext, b}) begin
            m_held_vld = 0;
        end
`endif
        if (b == 8'h12 && !ext) m_ls = !rel;
        if (b == 8'h59 && !ext) m_rs = !rel;
        if (b == 8'h14) begin if (ext) m_rc = !rel; else m_lc = !rel; end
        if (b == 8'h11) begin if (ext) m_ra = !rel; else m_la = !rel; end
        if (b == 8'h58 && !ext && !rel) m_caps = !m_caps;
        nw = {18'd0, m_caps, m_la | m_ra, m_lc | m_rc, m_ls | m_rs, rel, ext, b};
        np = !rel || m_rel_en;
    endtask

    // Prefix handling: E0 marks extended, F0 marks break unless a plain break
    // is already pending, in which case the byte completes the event
    task automatic model_byte(input logic [7:0] b, output bit np, output logic [31:0] nw);
        np = 0;
        nw = 0;
        if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0 && !(m_brk && !m_ext)) begin
            m_brk = 1;
        end else begin
            model_event(m_ext, m_brk, b, np, nw);
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    // One clock cycle of stimulus, model update and output checks
    task automatic do_cycle(input bit rdy, input logic [7:0] sc, input bit en,
                            input bit w, input logic [1:0] a, input logic [31:0] wd);
        logic [31:0] exp_rd;
        bit          exp_irq, do_pop, np, flush;
        logic [31:0] nw;
        ready = rdy; scancode = sc; ena = en; rw = w;
        addr = {28'd0, a, 2'b00}; wdata = wd;
        exp_irq = m_irq_en && (m_q.size() != 0);
        exp_rd = 0;
        do_pop = 0;
        if (en && !w) begin
            case (a)
                2'd0: if (m_q.size() != 0) begin exp_rd = m_q[0]; do_pop = 1; end
                2'd1: exp_rd = model_status();
                2'd2: exp_rd = {28'd0, m_irq_en, m_rel_en, 2'b00};
                default: exp_rd = 0;
            endcase
        end
        np = 0; nw = 0;
        if (rdy) model_byte(sc, np, nw);
        flush = en && w && a == 2'd2 && wd[0];
        if (do_pop) void'(m_q.pop_front());
        if (en && w && a == 2'd2 && wd[1]) m_ovf = 0;
        if (m_pend && !flush) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_pend_word);
            else m_ovf = 1;
        end
        if (flush) m_q.delete();
        if (en && w && a == 2'd2) begin
            m_rel_en = wd[2];
            m_irq_en = wd[3];
        end
        m_pend = np;
        m_pend_word = nw;
        @(posedge clk);
        #1;
        ready = 0; ena = 0; rw = 0;
        last_rd = rdata;
        check_eq("rdata", rdata, exp_rd);
        check_eq("irq", {31'd0, irq}, {31'd0, exp_irq});
    endtask

    task automatic send(input logic [7:0] b);
        do_cycle(1'b1, b, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic idle();
        do_cycle(1'b0, 8'd0, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic bus_rd(input logic [1:0] a);
        do_cycle(1'b0, 8'd0, 1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        do_cycle(1'b0, 8'd0, 1'b1, 1'b1, a, d);
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < DEPTH + 2; i++) bus_rd(2'd0);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        ready = 0; ena = 0; rw = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b1;
    endtask

    logic [7:0] pool [12];

    initial begin
        pool = '{8'hE0, 8'hF0, 8'h12, 8'h59, 8'h14, 8'h11,
                 8'h58, 8'h1C, 8'h1B, 8'h75, 8'h6B, 8'hE0};
        #1;
        do_reset();

        // Reset state
        bus_rd(2'd1); check_eq("reset_status", last_rd, 32'h0001_0000);
        bus_rd(2'd0); check_eq("reset_data", last_rd, 32'd0);

        // Make/break with release disabled
        send(8'h1C); send(8'hF0); send(8'h1C); idle();
        bus_rd(2'd0); check_eq("rel0_make", last_rd, 32'h0000_001C);
        bus_rd(2'd1); check_eq("rel0_status", last_rd, 32'h0001_0000);

        // Make/break with release enabled
        bus_wr(2'd2, 32'h4);
        send(8'h1C); send(8'hF0); send(8'h1C); idle();
        bus_rd(2'd0); check_eq("rel1_make", last_rd, 32'h0000_001C);
        bus_rd(2'd0); check_eq("rel1_break", last_rd, 32'h0000_021C);

        // Shift and extended sequences
        send(8'h12); send(8'h1C); send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75); send(8'hF0); send(8'h12); idle();
        bus_rd(2'd0); check_eq("seq_0", last_rd, 32'h0000_0412);
        bus_rd(2'd0); check_eq("seq_1", last_rd, 32'h0000_041C);
        bus_rd(2'd0); check_eq("seq_2", last_rd, 32'h0000_0575);
        bus_rd(2'd0); check_eq("seq_3", last_rd, 32'h0000_0775);
        bus_rd(2'd0); check_eq("seq_4", last_rd, 32'h0000_0212);
        bus_rd(2'd1); check_eq("seq_shift", last_rd & 32'h0008_0000, 32'd0);

        // Overflow: 17 makes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) send(8'(8'h20 + i));
        idle();
        bus_rd(2'd1); check_eq("ovf_status", last_rd, 32'h0006_0010);
        for (int i = 0; i < 16; i++) begin
            bus_rd(2'd0);
            check_eq("ovf_pop", last_rd, 32'(8'h20 + i));
        end
        bus_wr(2'd2, 32'h6);
        bus_rd(2'd1); check_eq("ovf_clear", last_rd, 32'h0001_0000);

        // Pop coinciding with push into a full FIFO
        for (int i = 0; i < 16; i++) send(8'(8'h31 + i));
        idle();
        send(8'h41);
        bus_rd(2'd0); check_eq("coin_pop", last_rd, 32'h0000_0031);
        bus_rd(2'd1); check_eq("coin_status", last_rd, 32'h0002_0010);
        bus_rd(2'd0); check_eq("coin_next", last_rd, 32'h0000_0032);
        drain();
        bus_rd(2'd1); check_eq("coin_drained", last_rd, 32'h0001_0000);

        // Auto-repeat stream
        bus_wr(2'd2, 32'h0);
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C); idle();
        bus_rd(2'd1);
`ifdef KBD_TYPEMATIC_FILTER_EN
        check_eq("typematic_cnt", last_rd, 32'h0000_0002);
`else
        check_eq("typematic_cnt", last_rd, 32'h0000_0004);
`endif
        drain();

        // Randomized traffic with interrupts enabled
        bus_wr(2'd2, 32'hC);
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            bit          rdy, en, w;
            logic [1:0]  a;
            logic [31:0] wd;
            r   = $urandom_range(0, 9);
            rdy = (r <= 3) || (r == 8);
            en  = (r >= 4) && (r <= 8);
            w   = ($urandom_range(0, 3) == 0);
            a   = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
            if (w) a = ($urandom_range(0, 1) == 0) ? 2'd2 : a;
            wd  = ($urandom & 32'hFFFF_FFFE) | {31'd0, ($urandom_range(0, 15) == 0)};
            do_cycle(rdy, pool[$urandom_range(0, 11)], en, w, a, wd);
        end
        drain();

        // Reset in the middle of a prefix sequence
        send(8'hE0);
        do_reset();
        send(8'h1C); idle();
        bus_rd(2'd0); check_eq("midframe_reset", last_rd, 32'h0000_001C);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
